// File: rtl/hex_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : hex_keypad_entry
// Description : 4x4 hex keypad scanner with frame-based press/release
//               debounce; accepted digits are shifted into a 32-bit word,
//               newest digit in the least significant nibble.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_keypad_entry #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    input  logic        clear,
    output logic [31:0] value,
    output logic [3:0]  digit_count,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]    DB_CNT     = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRESS_DB = 2'd1,
        S_HELD     = 2'd2,
        S_REL_DB   = 2'd3
    } state_t;

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_col;
    logic [1:0]    r_acc_cnt;   // lows seen so far this frame, saturating at 2
    logic [3:0]    r_acc_code;  // code of the single low seen so far
    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [3:0]    r_cand;

    logic [3:0] w_low;
    logic [2:0] w_pc;
    logic [1:0] w_row;
    logic [1:0] w_base;
    logic [2:0] w_sum;
    logic [1:0] w_tot;
    logic [3:0] w_fcode;
    logic       w_sample;
    logic       w_frame_end;
    logic       w_single;
    logic       w_none;
    logic [3:0] w_cnt_inc;
    logic       w_db_done;
    logic       w_accept;

    assign cols        = ~(4'b0001 << r_col);
    assign w_sample    = (r_dwell == DWELL_LAST);
    assign w_frame_end = w_sample && (r_col == 2'd3);

    // Two-flop synchronizer for the asynchronous, active-low row lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= rows;
            r_sync2 <= r_sync1;
        end
    end

    // Fold the current column sample into the running frame summary
    always_comb begin
        w_low = ~r_sync2;
        w_pc  = 3'(w_low[0]) + 3'(w_low[1]) + 3'(w_low[2]) + 3'(w_low[3]);
        w_row = 2'd0;
        if (w_low[0])      w_row = 2'd0;
        else if (w_low[1]) w_row = 2'd1;
        else if (w_low[2]) w_row = 2'd2;
        else if (w_low[3]) w_row = 2'd3;
        // column 0 opens a new frame, so nothing carries over into it
        w_base  = (r_col == 2'd0) ? 2'd0 : r_acc_cnt;
        w_sum   = {1'b0, w_base} + w_pc;
        w_tot   = (w_sum > 3'd1) ? 2'd2 : w_sum[1:0];
        w_fcode = (w_pc == 3'd1) ? {w_row, r_col} : r_acc_code;
    end

    // Column dwell counter, column rotation and per-frame accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell    <= '0;
            r_col      <= 2'd0;
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'd0;
        end else if (w_sample) begin
            r_dwell    <= '0;
            r_col      <= r_col + 2'd1;
            r_acc_cnt  <= w_tot;
            r_acc_code <= w_fcode;
        end else begin
            r_dwell    <= r_dwell + DW'(1);
        end
    end

    // Frame-level decode feeding the debounce state machine
    always_comb begin
        w_single  = w_frame_end && (w_tot == 2'd1);
        w_none    = w_frame_end && (w_tot == 2'd0);
        w_cnt_inc = r_cnt + 4'd1;
        w_db_done = (w_cnt_inc == DB_CNT);
        w_accept  = w_single &&
                    (((r_state == S_IDLE) && (DEBOUNCE == 1)) ||
                     ((r_state == S_PRESS_DB) && (w_fcode == r_cand) && w_db_done));
    end

    // Press/release debounce FSM with registered key strobe and code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_cand    <= 4'd0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            key_valid <= w_accept;
            if (w_accept) begin
                key_code <= w_fcode;
            end
            if (w_frame_end) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_single) begin
                            r_cand  <= w_fcode;
                            r_cnt   <= 4'd1;
                            r_state <= (DEBOUNCE == 1) ? S_HELD : S_PRESS_DB;
                        end
                    end
                    S_PRESS_DB: begin
                        if (w_single && (w_fcode == r_cand)) begin
                            r_cnt <= w_cnt_inc;
                            if (w_db_done) begin
                                r_state <= S_HELD;
                            end
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_HELD: begin
                        // a multi-key or different-key frame keeps the key held
                        if (w_none) begin
                            r_cnt   <= 4'd1;
                            r_state <= (DEBOUNCE == 1) ? S_IDLE : S_REL_DB;
                        end
                    end
                    S_REL_DB: begin
                        if (w_none) begin
                            r_cnt <= w_cnt_inc;
                            if (w_db_done) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_state <= S_HELD;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Digit word assembly; a clear on the accept edge keeps only the new digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value       <= 32'h0;
            digit_count <= 4'd0;
        end else if (w_accept) begin
            if (clear) begin
                value       <= {28'h0, w_fcode};
                digit_count <= 4'd1;
            end else begin
                value       <= {value[27:0], w_fcode};
                digit_count <= (digit_count == 4'd8) ? 4'd8 : digit_count + 4'd1;
            end
        end else if (clear) begin
            value       <= 32'h0;
            digit_count <= 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_keypad_entry
// Description : Self-checking bench for hex_keypad_entry; directed keypad
//               scenarios plus random frame-aligned key patterns compared
//               against a frame-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_keypad_entry;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        clear = 1'b0;
    logic [31:0] value;
    logic [3:0]  digit_count;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] keys  = 16'h0;   // bit (4*r + c) set = key (r,c) held

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;

    // Frame-level reference model state
    bit          m_armed = 1'b1;
    int          m_run   = 0;
    int          m_quiet = 0;
    logic [3:0]  m_key   = 4'h0;
    logic [3:0]  m_code  = 4'h0;
    logic [31:0] m_value = 32'h0;
    int          m_count = 0;

    hex_keypad_entry #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rows        (rows),
        .cols        (cols),
        .clear       (clear),
        .value       (value),
        .digit_count (digit_count),
        .key_valid   (key_valid),
        .key_code    (key_code)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a held key pulls its row low while its column is driven
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            rows[r] = ~|(keys[r*4 +: 4] & ~cols);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_armed = 1'b1;
        m_run   = 0;
        m_quiet = 0;
        m_key   = 4'h0;
        m_code  = 4'h0;
        m_value = 32'h0;
        m_count = 0;
    endfunction

    // One frame of keys in: a key is taken after DEBOUNCE consecutive frames
    // of it alone, and the pad re-arms only after DEBOUNCE empty frames.
    function automatic void model_frame(input logic [15:0] ks, output bit acc, output logic [3:0] code);
        int         n;
        logic [3:0] k;
        n    = $countones(ks);
        k    = 4'h0;
        acc  = 1'b0;
        code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (ks[i]) k = 4'(i);
        end
        if (m_armed) begin
            if (n == 1 && (m_run == 0 || k == m_key)) begin
                if (m_run == 0) m_key = k;
                m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run == DEBOUNCE) begin
                acc     = 1'b1;
                code    = m_key;
                m_armed = 1'b0;
                m_run   = 0;
                m_quiet = 0;
            end
        end else begin
            if (n == 0) begin
                m_quiet++;
                if (m_quiet == DEBOUNCE) begin
                    m_armed = 1'b1;
                    m_quiet = 0;
                end
            end else begin
                m_quiet = 0;
            end
        end
    endfunction

    // Advance the model by one frame and compare all outputs at the frame edge
    task automatic frame_end_checks(input logic [15:0] ks, input int clear_pos, input int extra);
        bit         acc;
        logic [3:0] k;
        if (clear_pos > 0 && clear_pos < FRAME) begin
            m_value = 32'h0;
            m_count = 0;
        end
        model_frame(ks, acc, k);
        if (acc) begin
            m_code = k;
            if (clear_pos == FRAME) begin
                m_value = {28'h0, k};
                m_count = 1;
            end else begin
                m_value = {m_value[27:0], k};
                if (m_count < 8) m_count++;
            end
        end else if (clear_pos == FRAME) begin
            m_value = 32'h0;
            m_count = 0;
        end
        if (key_valid) n_pulses++;
        check("kv_quiet", 32'(extra), 32'd0);
        check("key_valid", {31'h0, key_valid}, {31'h0, acc});
        check("key_code", {28'h0, key_code}, {28'h0, m_code});
        check("value", value, m_value);
        check("digit_count", {28'h0, digit_count}, 32'(m_count));
    endtask

    // Hold a key set for one frame; clear_pos selects the edge (1..16) CLEAR is high, 0 = none
    task automatic run_frame(input logic [15:0] ks, input int clear_pos);
        int extra;
        keys  = ks;
        extra = 0;
        for (int i = 1; i <= FRAME; i++) begin
            clear = (i == clear_pos);
            @(posedge clk);
            @(negedge clk);
            if (i < FRAME && key_valid) extra++;
        end
        clear = 1'b0;
        frame_end_checks(ks, clear_pos, extra);
    endtask

    task automatic run_frames(input logic [15:0] ks, input int n);
        for (int i = 0; i < n; i++) run_frame(ks, 0);
    endtask

    // Assert reset pre negedges into the current frame, check the immediate
    // reset state and the column rotation, and end aligned to a frame edge.
    task automatic do_reset(input int pre);
        int         extra;
        logic [3:0] exp_c;
        repeat (pre) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_cols", {28'h0, cols}, 32'hE);
        check("rst_value", value, 32'h0);
        check("rst_count", {28'h0, digit_count}, 32'h0);
        check("rst_kv", {31'h0, key_valid}, 32'h0);
        check("rst_code", {28'h0, key_code}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < FRAME; i++) begin
            #1;
            exp_c = ~(4'b0001 << (i / SCAN_DIV));
            check("cols_scan", {28'h0, cols}, {28'h0, exp_c});
            @(posedge clk);
            @(negedge clk);
            if (i < FRAME - 1 && key_valid) extra++;
        end
        frame_end_checks(keys, 0, extra);
    endtask

    initial begin
        int          base;
        logic [15:0] ks;
        int          a;
        int          b;
        int          dur;
        int          cp;

        @(negedge clk);
        do_reset(0);

        // single press of (r=1,c=2) held 6 frames: one pulse, no repeat
        base = n_pulses;
        run_frames(16'h1 << 6, 6);
        run_frames(16'h0, 3);
        check("single_pulses", 32'(n_pulses - base), 32'd1);
        check("single_code", {28'h0, key_code}, 32'h6);
        check("single_value", value, 32'h6);
        check("single_count", {28'h0, digit_count}, 32'd1);

        // nine digits overflow the eight-nibble word
        run_frame(16'h0, 8);
        base = n_pulses;
        for (int d = 1; d <= 9; d++) begin
            run_frames(16'h1 << d, 3);
            run_frames(16'h0, 3);
        end
        check("ovf_pulses", 32'(n_pulses - base), 32'd9);
        check("ovf_value", value, 32'h23456789);
        check("ovf_count", {28'h0, digit_count}, 32'd8);

        // one-frame bounce
        base = n_pulses;
        run_frames(16'h1 << 5, 1);
        run_frames(16'h0, 3);
        check("bounce_pulses", 32'(n_pulses - base), 32'd0);

        // 0x3 and 0xC together
        base = n_pulses;
        run_frames(16'h1008, 6);
        run_frames(16'h0, 3);
        check("multi_pulses", 32'(n_pulses - base), 32'd0);

        // 0x3 accepted, 0xC added, then 0x3 released with 0xC still down
        base = n_pulses;
        run_frames(16'h0008, 3);
        run_frames(16'h1008, 3);
        run_frames(16'h1000, 4);
        run_frames(16'h0, 3);
        check("partial_rel_pulses", 32'(n_pulses - base), 32'd1);

        // short release glitch while held
        base = n_pulses;
        run_frames(16'h1 << 7, 3);
        run_frames(16'h0, 1);
        run_frames(16'h1 << 7, 3);
        run_frames(16'h0, 3);
        check("rel_glitch_pulses", 32'(n_pulses - base), 32'd1);

        // clear coincident with accept of 0xA
        run_frame(16'h0, 5);
        for (int d = 1; d <= 4; d++) begin
            run_frames(16'h1 << d, 2);
            run_frames(16'h0, 2);
        end
        check("pre_clear_value", value, 32'h1234);
        run_frame(16'h1 << 10, 0);
        run_frame(16'h1 << 10, FRAME);
        check("clr_acc_value", value, 32'hA);
        check("clr_acc_count", {28'h0, digit_count}, 32'd1);
        check("clr_acc_code", {28'h0, key_code}, 32'hA);
        run_frames(16'h0, 3);

        // reset in PRESS_DB while the key stays down
        run_frame(16'h1 << 9, 0);
        base = n_pulses;
        do_reset(6);
        check("rst_pdb_first", 32'(n_pulses - base), 32'd0);
        run_frame(16'h1 << 9, 0);
        check("rst_pdb_second", 32'(n_pulses - base), 32'd1);
        check("rst_pdb_value", value, 32'h9);
        run_frames(16'h0, 3);

        // random frame-aligned key patterns
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 3))
                0: ks = 16'h0;
                1, 2: ks = 16'h1 << $urandom_range(0, 15);
                default: begin
                    a  = int'($urandom_range(0, 15));
                    b  = (a + 1 + int'($urandom_range(0, 14))) % 16;
                    ks = (16'h1 << a) | (16'h1 << b);
                end
            endcase
            dur = int'($urandom_range(1, 4));
            cp  = 0;
            if ($urandom_range(0, 9) == 0) cp = ($urandom_range(0, 1) == 0) ? 7 : FRAME;
            run_frame(ks, cp);
            run_frames(ks, dur - 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_keypad_entry.md
# hex_keypad_entry

Scans a 4x4 hex keypad matrix, debounces key presses, and assembles the accepted hex digits into a 32-bit word, most recent digit in the least significant nibble. Sits on the board I/O side of the RISC-V processor as the input counterpart of the 8-digit seven-segment display path. VALUE is sized to drive that display directly and to be read as a memory-mapped input word.

## Interface
- SCAN_DIV, 1000: clock cycles each column is driven; must be >= 4.
- DEBOUNCE, 4: consecutive identical scan frames required to accept a press or a release; range 1..15.
- CLK  in  1  system clock; all logic is rising-edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ROWS  in  4  keypad row lines, active-low, externally pulled up, asynchronous to CLK.
- COLS  out  4  keypad column drive, active-low one-cold.
- CLEAR  in  1  synchronous clear of VALUE and DIGIT_COUNT.
- VALUE  out  32  assembled word.
- DIGIT_COUNT  out  4  digits entered since reset/CLEAR, saturates at 8.
- KEY_VALID  out  1  one-cycle pulse on key acceptance.
- KEY_CODE  out  4  code of the last accepted key; held between pulses.

## Operation
- ROWS passes through a 2-flop synchronizer before use.
- Scan: column index c cycles 0,1,2,3,0,... and each value is held SCAN_DIV cycles. COLS = ~(1 << c).
- ROWS (synchronized) is sampled on the last cycle of each column dwell.
- Frame = 4 column dwells = 4*SCAN_DIV cycles. A frame is evaluated at the column-3 sample.
- Key code = 4*r + c for a low ROWS[r] seen while column c is driven.
- Frame result is one of:
  - NONE: no low row in any column.
  - SINGLE(code): exactly one low (r,c) in the frame.
  - MULTI: two or more lows; treated as NONE for acceptance and as "not released" in HELD.
- FSM states and transitions; cnt is the frame counter:
  - IDLE: SINGLE(k) -> cand=k, cnt=1, go to PRESS_DB. If DEBOUNCE=1, accept immediately and go to HELD.
  - PRESS_DB: SINGLE(cand) -> cnt++. When cnt reaches DEBOUNCE, accept and go to HELD. Any other result -> IDLE.
  - HELD: NONE -> cnt=1, go to REL_DB. If DEBOUNCE=1, go to IDLE. SINGLE or MULTI -> stay in HELD. There is no auto-repeat, including when a different key is pressed.
  - REL_DB: NONE -> cnt++. When cnt reaches DEBOUNCE, go to IDLE. SINGLE or MULTI -> HELD.
- Accept (single cycle):
  - KEY_VALID=1, KEY_CODE=cand.
  - VALUE <= {VALUE[27:0], cand}; the top nibble is discarded when more than 8 digits are entered.
  - DIGIT_COUNT <= min(DIGIT_COUNT+1, 8).
- CLEAR:
  - Sets VALUE=0 and DIGIT_COUNT=0 on the next edge.
  - Does not touch the scanner, FSM or KEY_CODE.
  - CLEAR coincident with an accept: result is VALUE={28'h0, cand}, DIGIT_COUNT=1, and KEY_VALID still pulses.
- Reset (asynchronous, may occur mid-scan or mid-debounce):
  - COLS=4'b1110 (c=0), dwell counter=0.
  - FSM=IDLE, cnt=0, synchronizer=4'hF.
  - VALUE=0, DIGIT_COUNT=0, KEY_VALID=0, KEY_CODE=0.
  - Any partial debounce is discarded.

## Timing
- Dwell counter counts 0..SCAN_DIV-1. The sample is taken at SCAN_DIV-1, and c advances on the following edge.
- Synchronizer latency is 2 cycles, which is covered because SCAN_DIV >= 4. ROWS must be stable within SCAN_DIV-3 cycles of a column change.
- Frame evaluation and FSM update are registered one cycle after the column-3 sample.
- KEY_VALID, KEY_CODE, VALUE and DIGIT_COUNT update together on that edge.
- Minimum press-to-KEY_VALID latency is DEBOUNCE frames plus 1 cycle, measured from the first frame fully seeing the press.
- At most one accept per press. Minimum spacing between accepts is 2*DEBOUNCE frames.
- KEY_VALID is high for exactly one cycle per accept.

## Test plan
The bench uses SCAN_DIV=4 and DEBOUNCE=2 (frame = 16 cycles). The keypad model drives ROWS[r]=0 when COLS[c]=0 and key (r,c) is held.
- Reset: assert RESET_N=0 mid-frame -> COLS=4'b1110, VALUE=0, DIGIT_COUNT=0, KEY_VALID=0, KEY_CODE=0 immediately. After release, COLS steps 1110, 1101, 1011, 0111 every 4 cycles.
- Single press: hold (r=1,c=2) for 6 frames, then release -> exactly one KEY_VALID, KEY_CODE=6, VALUE=32'h6, DIGIT_COUNT=1, and no repeat while held.
- Overflow: enter keys 1..9 with full release between each -> VALUE=32'h23456789, DIGIT_COUNT=8, nine KEY_VALID pulses.
- Bounce/multi:
  - A press lasting 1 frame -> no KEY_VALID.
  - Keys 0x3 and 0xC held together for 6 frames -> no KEY_VALID.
  - Release of one key while the other remains held -> no KEY_VALID.
- Release debounce: in HELD, release for 1 frame then re-press the same key -> no second KEY_VALID.
- CLEAR and reset corner cases:
  - With VALUE=32'h1234, assert CLEAR on the accept cycle of key 0xA -> VALUE=32'hA, DIGIT_COUNT=1.
  - Reset during PRESS_DB, then keep holding the key -> accept occurs only after 2 fresh frames.
